// File: rtl/acc_beat_driver.sv
// acc_beat_driver: emits an arithmetic beat sequence into an accumulator and checks its final value
module acc_beat_driver #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] step,
    input  logic [CNT_W-1:0]  count,
    input  logic [GAP_W-1:0]  gap,
    input  logic [63:0]       cycles,
    input  logic [DATA_W-1:0] accumulator,
    output logic              valid,
    output logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [DATA_W-1:0] expected,
    output logic [63:0]       elapsed
);
    typedef enum logic [1:0] {IDLE, EMIT, GAP, SETTLE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] cur, step_r;
    logic [CNT_W-1:0]  remaining;
    logic [GAP_W-1:0]  gap_cfg, gap_cnt;
    logic [63:0]       start_cyc;

    assign valid = state == EMIT;
    assign busy  = state != IDLE;
    assign value = cur;

    // state register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    // next-state: a zero-length run goes straight to the check cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (count == '0) ? SETTLE : EMIT;
            EMIT:    state_nx = (remaining == CNT_W'(1)) ? SETTLE : (gap_cfg != '0) ? GAP : EMIT;
            GAP:     if (gap_cnt == GAP_W'(1)) state_nx = EMIT;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: latch the command, advance the beat and running sum, check in SETTLE
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            cur       <= '0;
            step_r    <= '0;
            remaining <= '0;
            gap_cfg   <= '0;
            gap_cnt   <= '0;
            expected  <= '0;
            start_cyc <= '0;
            elapsed   <= '0;
            match     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= state == SETTLE;
            case (state)
                IDLE: if (start) begin
                    cur       <= base;
                    step_r    <= step;
                    remaining <= count;
                    gap_cfg   <= gap;
                    expected  <= accumulator;
                    start_cyc <= cycles;
                end
                EMIT: begin
                    expected  <= expected + cur;
                    cur       <= cur + step_r;
                    remaining <= remaining - CNT_W'(1);
                    gap_cnt   <= gap_cfg;
                end
                GAP:    gap_cnt <= gap_cnt - GAP_W'(1);
                SETTLE: begin
                    match   <= accumulator == expected;
                    elapsed <= cycles - start_cyc;
                end
                default: ;
            endcase
        end
endmodule

// File: doc/acc_beat_driver.md
# acc_beat_driver

Hardware stimulus source for the accumulator valid/value interface in the HSE virtual-RTL example. Today the Lua script behind `u_empty` drives that interface; this block drives it from RTL instead. On a start command it emits a programmed arithmetic sequence of beats, with an optional idle gap between beats. It then checks the accumulator it fed against its own running sum and reports the result, a match flag and the elapsed cycle count.

## Interface
- `DATA_W`, default 32: width of `value`, `base`, `step`, `accumulator`, `expected`.
- `CNT_W`, default 16: width of `count`.
- `GAP_W`, default 8: width of `gap`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base`  in  DATA_W  first beat value.
- `step`  in  DATA_W  increment between beats.
- `count`  in  CNT_W  number of beats; 0 is legal.
- `gap`  in  GAP_W  idle cycles between consecutive beats.
- `cycles`  in  64  free-running cycle counter from top.
- `accumulator`  in  DATA_W  accumulator register being fed.
- `valid`  out  1  beat valid; high exactly in EMIT.
- `value`  out  DATA_W  beat data (current-value register).
- `busy`  out  1  high in EMIT, GAP and SETTLE.
- `done`  out  1  one-cycle completion pulse.
- `match`  out  1  result of the last check; held until the next check.
- `expected`  out  DATA_W  accumulator snapshot plus the sum of all emitted beats.
- `elapsed`  out  64  `cycles` at SETTLE minus `cycles` at start.

## Operation
- States: IDLE, EMIT, GAP, SETTLE.
- Registers: `cur`, `remaining`, `gap_cfg`, `gap_cnt`, `expected`, `start_cyc`, `elapsed`, `match`, `done`.
- IDLE with `start`=1 at an edge:
  - latch `cur`=`base`, step, `remaining`=`count`, `gap_cfg`=`gap`;
  - `expected`=`accumulator`, `start_cyc`=`cycles`;
  - next state is EMIT, or SETTLE if `count`=0.
- `start` outside IDLE is ignored. Parameters are not re-sampled mid-run.
- EMIT edge:
  - `expected` += `cur`, `cur` += step, `remaining` -= 1;
  - if `remaining` was 1, go to SETTLE;
  - else if `gap_cfg`>0, load `gap_cnt`=`gap_cfg` and go to GAP;
  - else stay in EMIT (back-to-back beats).
- GAP edge: `gap_cnt` -= 1; when it reaches 0, go to EMIT. `valid`=0 throughout GAP.
- SETTLE is one cycle. It exists because the accumulator absorbs the last beat on the edge that ends EMIT. At the SETTLE edge:
  - `match` <= (`accumulator` == `expected`);
  - `elapsed` <= `cycles` − `start_cyc`;
  - `done` <= 1;
  - next state IDLE.
- `done` clears on the following edge. A `start` present during the `done` cycle is accepted.
- All arithmetic is modulo 2^DATA_W (`elapsed` modulo 2^64). No saturation, no overflow flag.
- This block assumes it is the sole driver of the accumulator. Any foreign update during a run yields `match`=0.

## Timing
- Reset values: `valid`=0, `value`=0, `busy`=0, `done`=0, `match`=0, `expected`=0, `elapsed`=0, state IDLE.
- Reset assertion clears all outputs immediately, without waiting for a clock edge, including mid-run. A run interrupted by reset is abandoned and produces no `done`.
- Start sampled at edge T:
  - beat i (0-based) is valid during cycle T+1+i·(gap+1);
  - SETTLE occupies cycle T+2+(count−1)·(gap+1);
  - `done` is high the cycle after SETTLE.
- Resulting `elapsed` = (count−1)·(gap+1)+2.
- `count`=0: SETTLE occupies cycle T+1, `done` is high in cycle T+2, `elapsed`=1.
- `valid` and `value` come straight from registers; no combinational path from inputs to outputs.

## Test plan
- Single run, no gap:
  - stimulus: accumulator=0, base=5, step=3, count=4, gap=0;
  - required: `value` 5,8,11,14 on four consecutive cycles; `expected`=38, `match`=1, `elapsed`=5, one `done` pulse.
- Gap spacing:
  - stimulus: base=1, step=1, count=3, gap=2;
  - required: `valid` pattern 1,0,0,1,0,0,1; sum 6, `match`=1, `elapsed`=8.
- Zero count:
  - stimulus: count=0, accumulator=100;
  - required: `valid` never asserted; `done` two cycles after start; `expected`=100, `match`=1, `elapsed`=1.
- Wrap-around:
  - stimulus: accumulator=0, base=0xFFFF_FFFF, step=1, count=2;
  - required: `value` 0xFFFF_FFFF then 0x0000_0000; `expected`=0xFFFF_FFFF, `match`=1.
- Reset mid-run:
  - stimulus: `reset_n` low during the second beat;
  - required: `valid`, `busy` and `expected` drop to 0 without a clock edge; no `done`; a new start after release completes normally.
- Mismatch and ignored start:
  - stimulus: a second `start` pulsed during EMIT; the bench adds +1 to the accumulator mid-run;
  - required: second command ignored (beat count unchanged); `match`=0 at `done`; back-to-back start in the `done` cycle is accepted.
